// File: rtl/ioctl_upload_responder.sv
// Answers hps_io upload (save) requests for one ioctl_index by pausing the core and
// streaming bytes out of its NVRAM/hiscore RAM port, stalling the HPS with ioctl_wait.
module ioctl_upload_responder #(
    parameter int unsigned INDEX  = 4,
    parameter int unsigned AW     = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk_sys_i,
    input  logic          reset_n_i,
    input  logic          ioctl_upload_i,
    input  logic [7:0]    ioctl_index_i,
    input  logic          ioctl_rd_i,
    input  logic [26:0]   ioctl_addr_i,
    output logic [7:0]    ioctl_din_o,
    output logic          ioctl_wait_o,
    output logic          pause_req_o,
    input  logic          pause_ack_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [7:0]    mem_dout_i,
    output logic          mem_own_o,
    output logic [15:0]   bytes_read_o,
    output logic          upload_done_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPause = 2'd1;
    localparam logic [1:0] StReady = 2'd2;
    localparam logic [1:0] StFetch = 2'd3;

    localparam logic [26:0] DepthW = 27'(DEPTH);
    localparam logic [2:0]  RdLatW = 3'(RD_LAT);
    localparam logic [7:0]  IndexW = 8'(INDEX);

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [15:0]   bytes_q, bytes_d;
    logic          done_q, done_d;
    logic          seen_q, seen_d;

    logic          active;
    logic          in_range;
    logic [15:0]   bytes_inc;

    assign active    = ioctl_upload_i && (ioctl_index_i == IndexW);
    assign in_range  = ioctl_addr_i < DepthW;
    assign bytes_inc = (bytes_q == 16'hFFFF) ? bytes_q : bytes_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        bytes_d = bytes_q;
        done_d  = 1'b0;
        seen_d  = seen_q;
        // Losing the session wins over everything, including an in-flight fetch.
        if (state_q != StIdle && !active) begin
            state_d = StIdle;
            done_d  = seen_q;
        end else begin
            case (state_q)
                StIdle: begin
                    if (active) begin
                        state_d = StPause;
                        bytes_d = 16'd0;
                        seen_d  = 1'b0;
                    end
                end
                StPause: begin
                    if (pause_ack_i) begin
                        state_d = StReady;
                        seen_d  = 1'b1;
                    end
                end
                StReady: begin
                    if (ioctl_rd_i) begin
                        if (in_range) begin
                            state_d = StFetch;
                            cnt_d   = 3'd1;
                            addr_d  = ioctl_addr_i[AW-1:0];
                        end else begin
                            din_d   = 8'hFF;
                            bytes_d = bytes_inc;
                        end
                    end else if (!pause_ack_i) begin
                        state_d = StPause;
                    end
                end
                StFetch: begin
                    if (cnt_q == RdLatW) begin
                        din_d   = mem_dout_i;
                        bytes_d = bytes_inc;
                        state_d = pause_ack_i ? StReady : StPause;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            din_q   <= 8'h00;
            bytes_q <= 16'd0;
            done_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            bytes_q <= bytes_d;
            done_q  <= done_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        pause_req_o = state_q != StIdle;
        mem_own_o   = (state_q == StReady) || (state_q == StFetch);
        ioctl_wait_o = 1'b0;
        unique case (state_q)
            StPause: ioctl_wait_o = 1'b1;
            StReady: ioctl_wait_o = ioctl_rd_i;
            StFetch: ioctl_wait_o = 1'b1;
            default: ioctl_wait_o = 1'b0;
        endcase
        mem_rd_o   = (state_q == StReady) && ioctl_rd_i && in_range && active;
        mem_addr_o = ((state_q == StReady) && ioctl_rd_i) ? ioctl_addr_i[AW-1:0] : addr_q;
    end

    assign ioctl_din_o   = din_q;
    assign bytes_read_o  = bytes_q;
    assign upload_done_o = done_q;

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Directed bench for ioctl_upload_responder against a 2-cycle-latency RAM model.
module tb_ioctl_upload_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upload = 1'b0;
    logic [7:0]  index = 8'd0;
    logic        rd = 1'b0;
    logic [26:0] addr = 27'd0;
    logic [7:0]  din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack = 1'b0;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_dout;
    logic        mem_own;
    logic [15:0] bytes_read;
    logic        upload_done;

    logic [7:0]  mem [1024];
    logic [7:0]  pipe1, pipe2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ioctl_upload_responder #(
        .INDEX(4), .AW(10), .DEPTH(1024), .RD_LAT(2)
    ) dut (
        .clk_sys_i     (clk),
        .reset_n_i     (rst_n),
        .ioctl_upload_i(upload),
        .ioctl_index_i (index),
        .ioctl_rd_i    (rd),
        .ioctl_addr_i  (addr),
        .ioctl_din_o   (din),
        .ioctl_wait_o  (ioctl_wait),
        .pause_req_o   (pause_req),
        .pause_ack_i   (pause_ack),
        .mem_addr_o    (mem_addr),
        .mem_rd_o      (mem_rd),
        .mem_dout_i    (mem_dout),
        .mem_own_o     (mem_own),
        .bytes_read_o  (bytes_read),
        .upload_done_o (upload_done)
    );

    // RAM model: data for a strobed address appears two clocks after mem_rd.
    always @(posedge clk) begin
        pipe1 <= mem_rd ? mem[mem_addr] : 8'h00;
        pipe2 <= pipe1;
    end
    assign mem_dout = pipe2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, din, ioctl_wait, pause_req, mem_own, mem_rd, bytes_read, upload_done,
                mem_addr};
    endfunction

    initial begin
        int wait_cnt;
        int errs;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 13);
        mem[5] = 8'hA5;

        // Reset state
        tick(); tick();
        chk("reset_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_after_reset", {pause_req, ioctl_wait, mem_own}, 3'b000);

        // Wrong index is ignored
        upload = 1'b1; index = 8'd3; rd = 1'b1; addr = 27'd5;
        #1;
        chk("wrong_idx_wait", ioctl_wait, 1'b0);
        chk("wrong_idx_memrd", mem_rd, 1'b0);
        tick(); rd = 1'b0; tick();
        chk("wrong_idx_pause", pause_req, 1'b0);
        upload = 1'b0; tick();

        // Basic read of address 5
        index = 8'd4; upload = 1'b1;
        #1;
        chk("idle_no_pause_yet", pause_req, 1'b0);
        tick();
        chk("pause_state", {pause_req, ioctl_wait, mem_own}, 3'b110);
        tick(); tick();
        pause_ack = 1'b1;
        tick();
        chk("ready_state", {pause_req, ioctl_wait, mem_own}, 3'b101);
        rd = 1'b1; addr = 27'd5;
        #1;
        chk("basic_memrd", {mem_rd, ioctl_wait}, 2'b11);
        chk("basic_memaddr", mem_addr, 10'd5);
        wait_cnt = 1;
        tick(); rd = 1'b0; #1;
        chk("basic_memrd_once", mem_rd, 1'b0);
        chk("basic_addr_held", mem_addr, 10'd5);
        for (int k = 0; k < 10; k++) begin
            if (!ioctl_wait) break;
            wait_cnt++;
            tick();
        end
        chk("basic_wait_cycles", wait_cnt, 3);
        chk("basic_din", din, 8'hA5);
        chk("basic_bytes", bytes_read, 16'd1);

        // Out-of-range read
        rd = 1'b1; addr = 27'd1024;
        #1;
        chk("oor_no_memrd", mem_rd, 1'b0);
        chk("oor_wait_c0", ioctl_wait, 1'b1);
        tick(); rd = 1'b0; #1;
        chk("oor_wait_c1", ioctl_wait, 1'b0);
        chk("oor_din", din, 8'hFF);
        chk("oor_bytes", bytes_read, 16'd2);

        // pause_ack drop while READY
        pause_ack = 1'b0;
        tick();
        chk("unack_1", {ioctl_wait, mem_own}, 2'b10);
        tick();
        chk("unack_2", {ioctl_wait, mem_own}, 2'b10);
        pause_ack = 1'b1;
        tick();
        chk("reack", {ioctl_wait, mem_own}, 2'b01);

        // Abort mid-FETCH
        rd = 1'b1; addr = 27'd6;
        tick(); rd = 1'b0; upload = 1'b0;
        #1;
        chk("abort_wait_fetch", ioctl_wait, 1'b1);
        tick();
        chk("abort_idle", {pause_req, mem_own, ioctl_wait, upload_done}, 4'b0001);
        chk("abort_din_kept", din, 8'hFF);
        tick();
        chk("abort_done_once", upload_done, 1'b0);
        chk("abort_din_still", din, 8'hFF);
        chk("abort_bytes_hold", bytes_read, 16'd2);

        // Sequential dump of all bytes
        upload = 1'b1;
        tick();
        chk("dump_bytes_clear", bytes_read, 16'd0);
        tick();
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            rd = 1'b1; addr = 27'(i);
            tick(); rd = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (!ioctl_wait) break;
                tick();
            end
            if (ioctl_wait || din !== mem[i]) errs++;
        end
        chk("dump_data", errs, 0);
        chk("dump_bytes", bytes_read, 16'd1024);
        upload = 1'b0;
        #1;
        chk("dump_pre_end", {pause_req, upload_done}, 2'b10);
        tick();
        chk("dump_done", {pause_req, upload_done}, 2'b01);
        tick();
        chk("dump_done_once", upload_done, 1'b0);
        chk("dump_bytes_hold", bytes_read, 16'd1024);

        // Reset mid-FETCH
        upload = 1'b1;
        tick(); tick();
        rd = 1'b1; addr = 27'd7;
        tick(); rd = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 64'd0);
        upload = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_reset_idle", {pause_req, upload_done, mem_own}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
